// File: rtl/demux_1t4_buf.sv
// rtl/demux_1t4_buf.sv - 1-to-4 buffered demultiplexer with a 2-entry FIFO per output port
module demux_1t4_buf #(
  parameter int DW    = 5,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_sel,
  input  logic [DW-1:0]   in_data,
  output logic [3:0]      out_valid,
  input  logic [3:0]      out_ready,
  output logic [4*DW-1:0] out_data,
  output logic [7:0]      occ
);

  // Occupancy value at which a port refuses a push unless it pops the same cycle.
  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [DW-1:0] mem [4][2];
  logic [3:0]    wptr;
  logic [3:0]    rptr;
  logic [1:0]    cnt [4];
  logic [3:0]    push;
  logic [3:0]    pop;

  // A full port still accepts when its consumer drains the head in the same
  // cycle; the new item lands in the slot being freed.
  assign in_ready = rst_n & ~flush & ((cnt[in_sel] != FULL) | out_ready[in_sel]);

  // Decode the single push onto its port and qualify each port's pop.
  always_comb begin
    push = 4'b0;
    pop  = 4'b0;
    for (int k = 0; k < 4; k++) begin
      push[k] = in_valid & in_ready & (in_sel == 2'(k));
      pop[k]  = out_valid[k] & out_ready[k];
    end
  end

  // Heads are read straight from registered storage; no same-cycle bypass.
  always_comb begin
    out_valid = 4'b0;
    out_data  = '0;
    occ       = 8'b0;
    for (int k = 0; k < 4; k++) begin
      out_valid[k]          = (cnt[k] != 2'd0);
      out_data[k*DW +: DW]  = mem[k][rptr[k]];
      occ[2*k +: 2]         = cnt[k];
    end
  end

  // Per-port FIFO state; reset also clears storage so heads are never X,
  // flush only rewinds pointers and counts and overrides any push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= 4'b0;
      rptr <= 4'b0;
      for (int k = 0; k < 4; k++) begin
        cnt[k]    <= 2'd0;
        mem[k][0] <= '0;
        mem[k][1] <= '0;
      end
    end else if (flush) begin
      wptr <= 4'b0;
      rptr <= 4'b0;
      for (int k = 0; k < 4; k++) begin
        cnt[k] <= 2'd0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (push[k]) begin
          mem[k][wptr[k]] <= in_data;
          wptr[k]         <= ~wptr[k];
        end
        if (pop[k]) begin
          rptr[k] <= ~rptr[k];
        end
        case ({push[k], pop[k]})
          2'b10:   cnt[k] <= cnt[k] + 2'd1;
          2'b01:   cnt[k] <= cnt[k] - 2'd1;
          default: cnt[k] <= cnt[k];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demux_1t4_buf.sv
// tb/tb_demux_1t4_buf.sv - directed vector table plus scoreboarded traffic for demux_1t4_buf
module tb_demux_1t4_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [4:0]  in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [19:0] out_data;
  logic [7:0]  occ;

  int checks = 0;
  int errors = 0;

  demux_1t4_buf #(.DW(5), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occ       (occ)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        flush;
    logic        vld;
    logic [1:0]  sel;
    logic [4:0]  din;
    logic [3:0]  ordy;
    logic        rdy;
    logic [3:0]  ov;
    logic [7:0]  occ;
    logic [19:0] data;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  logic [4:0] sbq [4][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic f, input logic v, input logic [1:0] s,
                              input logic [4:0] d, input logic [3:0] o, input logic rd,
                              input logic [3:0] ov, input logic [7:0] oc, input logic [19:0] da);
    vec_t t;
    t.rst_n = r; t.flush = f; t.vld = v; t.sel = s; t.din = d; t.ordy = o;
    t.rdy = rd; t.ov = ov; t.occ = oc; t.data = da;
    return t;
  endfunction

  initial begin
    logic [19:0] mask;
    logic        exp_rdy;
    logic [3:0]  ordy;
    logic        vld;
    logic [1:0]  sel;
    logic [4:0]  din;
    int          pushes;
    int          cyc;

    //            rst f  v  sel   din    ordy     rdy  ov       occ     data {P3,P2,P1,P0}
    tbl[0]  = mk(0, 0, 1, 2'd0, 5'h00, 4'b0000, 0, 4'b0000, 8'h00, 20'h0);
    tbl[1]  = mk(0, 0, 1, 2'd0, 5'h00, 4'b0000, 0, 4'b0000, 8'h00, 20'h0);
    tbl[2]  = mk(1, 0, 1, 2'd2, 5'h1F, 4'b0000, 1, 4'b0100, 8'h10, {5'h0, 5'h1F, 5'h0, 5'h0});
    tbl[3]  = mk(1, 0, 0, 2'd0, 5'h00, 4'b0100, 1, 4'b0000, 8'h00, 20'h0);
    tbl[4]  = mk(1, 0, 1, 2'd1, 5'h03, 4'b0000, 1, 4'b0010, 8'h04, {5'h0, 5'h0, 5'h03, 5'h0});
    tbl[5]  = mk(1, 0, 1, 2'd1, 5'h04, 4'b0000, 1, 4'b0010, 8'h08, {5'h0, 5'h0, 5'h03, 5'h0});
    tbl[6]  = mk(1, 0, 1, 2'd1, 5'h1E, 4'b0000, 0, 4'b0010, 8'h08, {5'h0, 5'h0, 5'h03, 5'h0});
    tbl[7]  = mk(1, 0, 0, 2'd0, 5'h00, 4'b0000, 1, 4'b0010, 8'h08, {5'h0, 5'h0, 5'h03, 5'h0});
    tbl[8]  = mk(1, 0, 1, 2'd1, 5'h05, 4'b0010, 1, 4'b0010, 8'h08, {5'h0, 5'h0, 5'h04, 5'h0});
    tbl[9]  = mk(1, 0, 0, 2'd1, 5'h00, 4'b0010, 1, 4'b0010, 8'h04, {5'h0, 5'h0, 5'h05, 5'h0});
    tbl[10] = mk(1, 0, 1, 2'd1, 5'h06, 4'b0010, 1, 4'b0010, 8'h04, {5'h0, 5'h0, 5'h06, 5'h0});
    tbl[11] = mk(1, 0, 0, 2'd1, 5'h00, 4'b0010, 1, 4'b0000, 8'h00, 20'h0);
    tbl[12] = mk(1, 0, 1, 2'd0, 5'h11, 4'b0000, 1, 4'b0001, 8'h01, {5'h0, 5'h0, 5'h0, 5'h11});
    tbl[13] = mk(1, 0, 1, 2'd0, 5'h12, 4'b0000, 1, 4'b0001, 8'h02, {5'h0, 5'h0, 5'h0, 5'h11});
    tbl[14] = mk(1, 0, 1, 2'd3, 5'h13, 4'b0000, 1, 4'b1001, 8'h42, {5'h13, 5'h0, 5'h0, 5'h11});
    tbl[15] = mk(1, 0, 1, 2'd3, 5'h14, 4'b0000, 1, 4'b1001, 8'h82, {5'h13, 5'h0, 5'h0, 5'h11});
    tbl[16] = mk(1, 1, 1, 2'd0, 5'h0A, 4'b1111, 0, 4'b0000, 8'h00, 20'h0);
    tbl[17] = mk(1, 0, 0, 2'd0, 5'h00, 4'b0000, 1, 4'b0000, 8'h00, 20'h0);
    tbl[18] = mk(1, 0, 1, 2'd0, 5'h15, 4'b0000, 1, 4'b0001, 8'h01, {5'h0, 5'h0, 5'h0, 5'h15});
    tbl[19] = mk(0, 0, 1, 2'd0, 5'h01, 4'b0000, 0, 4'b0000, 8'h00, 20'h0);

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = 5'h0; out_ready = 4'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst_n = tbl[i].rst_n; flush = tbl[i].flush; in_valid = tbl[i].vld;
      in_sel = tbl[i].sel; in_data = tbl[i].din; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("v%0d occ", i), 32'(occ), 32'(tbl[i].occ));
      mask = '0;
      for (int k = 0; k < 4; k++)
        if (tbl[i].ov[k] || !tbl[i].rst_n) mask[k*5 +: 5] = 5'h1F;
      chk($sformatf("v%0d out_data", i), 32'(out_data & mask), 32'(tbl[i].data & mask));
    end

    // Release reset and run random traffic against per-port queues.
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 4'b0;
    @(posedge clk);
    pushes = 0;
    cyc = 0;
    while (pushes < 8 && cyc < 200) begin
      @(negedge clk);
      vld  = ($urandom_range(0, 3) != 0);
      sel  = 2'($urandom_range(0, 3));
      din  = 5'($urandom_range(0, 31));
      ordy = 4'($urandom_range(0, 15));
      in_valid = vld; in_sel = sel; in_data = din; out_ready = ordy;
      #1;
      exp_rdy = (sbq[sel].size() != 2) || ordy[sel];
      chk($sformatf("r%0d in_ready", cyc), 32'(in_ready), 32'(exp_rdy));
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("r%0d out_valid[%0d]", cyc, k), 32'(out_valid[k]), 32'(sbq[k].size() != 0));
        if (sbq[k].size() != 0)
          chk($sformatf("r%0d head[%0d]", cyc, k), 32'(out_data[k*5 +: 5]), 32'(sbq[k][0]));
      end
      for (int k = 0; k < 4; k++)
        if (ordy[k] && sbq[k].size() != 0) void'(sbq[k].pop_front());
      if (vld && exp_rdy) begin
        sbq[sel].push_back(din);
        pushes++;
      end
      @(posedge clk);
      cyc++;
    end
    if (pushes < 8) chk("random traffic budget", 32'(pushes), 32'd8);

    // Drain every port and confirm each remaining item emerges in order.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 4'b1111;
      #1;
      for (int k = 0; k < 4; k++)
        if (sbq[k].size() != 0) begin
          chk($sformatf("drain%0d head[%0d]", c, k), 32'(out_data[k*5 +: 5]), 32'(sbq[k][0]));
          void'(sbq[k].pop_front());
        end
      @(posedge clk);
    end
    #1;
    chk("drained occ", 32'(occ), 32'd0);
    chk("drained out_valid", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
